toggle_pulse_decoder: RTL and testbench
=======================================

TOGGLE_PULSE_DECODER -- requirements
Module: toggle_pulse_decoder

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, width of the event counter.
REQ-002 The module SHALL have parameter PEND_W, default 2, width of the pending-event counter (max pending = 2^PEND_W-1 = 3).
REQ-003 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The module SHALL have port tog_in, input, 1, toggle-encoded event level; each transition (0->1 or 1->0) is one event; may be asynchronous to clk.
REQ-006 The module SHALL have port evt_ack, input, 1, consumer acknowledge for one pending event.
REQ-007 The module SHALL have port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-008 The module SHALL have port tog_pulse, output, 1, registered single-cycle pulse per detected event.
REQ-009 The module SHALL have port evt_valid, output, 1, high while at least one event is pending.
REQ-010 The module SHALL have port pending, output, PEND_W, number of unacknowledged events.
REQ-011 The module SHALL have port evt_count, output, CNT_W, total detected events, modulo 2^CNT_W.
REQ-012 The module SHALL have port ovf, output, 1, sticky flag for an event lost because pending was full.

Function
REQ-013 tog_in SHALL pass through a 3-register chain s1->s2->s3; an event SHALL be detected at a rising edge when s2 XOR s3 is 1 and the module is armed.
REQ-014 A 2-bit warm-up counter SHALL increment on each edge after reset release and saturate at 3; the module is armed only when this counter, before the edge, equals 3.
REQ-015 Detection SHALL be suppressed while unarmed, so a tog_in held at 1 through reset produces no event.
REQ-016 Latency: for a tog_in transition meeting setup before edge N, tog_pulse SHALL be high for exactly the cycle after edge N+2.
REQ-017 Each tog_in transition SHALL yield exactly one tog_pulse; transitions spaced at least 2 cycles apart SHALL never be merged or lost.
REQ-018 evt_count SHALL increment by 1 on each detected event and wrap from 2^CNT_W-1 to 0.
REQ-019 evt_valid SHALL equal (pending != 0), derived from the registered pending value.
REQ-020 An evt_ack while evt_valid is high SHALL decrement pending by 1; an evt_ack while evt_valid is low SHALL be ignored.
REQ-021 A detected event SHALL increment pending by 1 when pending < max.
REQ-022 A detected event and an accepted evt_ack in the same cycle SHALL leave pending unchanged, with no overflow.
REQ-023 A detected event with pending = max and no accepted evt_ack SHALL leave pending at max and set ovf; evt_count still increments.
REQ-024 ovf SHALL remain set until clr_ovf; if clr_ovf and a new overflow occur in the same cycle, ovf SHALL be 1 afterwards.
REQ-025 All outputs SHALL be driven directly from registers.

Reset
REQ-026 While rst is high, s1, s2, s3, the warm-up counter, tog_pulse, pending, evt_count and ovf SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard pending events and counts; after release, REQ-014/015 apply again.

Verification
REQ-028 The bench SHALL drive tog_in=1 through reset, release it, and hold for 10 cycles, requiring tog_pulse=0, evt_count=0 and pending=0 throughout.
REQ-029 The bench SHALL drive tog_in 0->1 after warm-up with no ack, requiring tog_pulse high one cycle, 3 edges after the transition, then evt_count=1, pending=1 and evt_valid=1.
REQ-030 The bench SHALL issue 5 toggles spaced 4 cycles apart with no ack, requiring pending to reach 3, ovf=1 after the 4th event, and evt_count=5.
REQ-031 The bench SHALL hold evt_ack high during a detect cycle with pending=2, requiring pending to stay 2; it SHALL then ack 3 times, requiring the 3rd ack to be ignored with pending=0.
REQ-032 The bench SHALL apply 256 toggles with CNT_W=8, requiring evt_count to wrap to 0; it SHALL then pulse clr_ovf and require ovf=0.
REQ-033 The bench SHALL assert rst asynchronously between clock edges with pending=2 and ovf=1, requiring all outputs to reach 0 before the next edge.

Source files
------------

// File: rtl/toggle_pulse_decoder.sv
// Turns a toggle-encoded event line into one registered pulse per transition.
// Events are counted, queued as a small pending count, and losses raise a sticky overflow.
module toggle_pulse_decoder #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  input  logic              evt_ack,
  input  logic              clr_ovf,
  output logic              tog_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              s1, s2, s3;
  logic [1:0]        warm;
  logic              armed;
  logic              detect;
  logic              ack_ok;
  logic [PEND_W-1:0] pending_nxt;
  logic              ovf_nxt;

  // A simultaneous detect and accepted ack cancel out; a new overflow beats clr_ovf.
  always_comb begin
    armed       = (warm == 2'd3);
    detect      = armed & (s2 ^ s3);
    ack_ok      = evt_ack & (pending != '0);
    pending_nxt = pending;
    ovf_nxt     = ovf;
    if (clr_ovf)
      ovf_nxt = 1'b0;
    if (detect && !ack_ok) begin
      if (pending == PEND_MAX)
        ovf_nxt = 1'b1;
      else
        pending_nxt = pending + 1'b1;
    end else if (!detect && ack_ok) begin
      pending_nxt = pending - 1'b1;
    end
  end

  // The warm-up counter keeps the synchroniser's reset-time contents from looking like an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      warm      <= 2'd0;
      tog_pulse <= 1'b0;
      evt_valid <= 1'b0;
      pending   <= '0;
      evt_count <= '0;
      ovf       <= 1'b0;
    end else begin
      s1        <= tog_in;
      s2        <= s1;
      s3        <= s2;
      if (warm != 2'd3)
        warm <= warm + 2'd1;
      tog_pulse <= detect;
      if (detect)
        evt_count <= evt_count + 1'b1;
      pending   <= pending_nxt;
      evt_valid <= (pending_nxt != '0);
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed bench for toggle_pulse_decoder: inputs change on the falling edge,
// and outputs are sampled there too, away from the rising clock edge.
module tb_toggle_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tog_in;
  logic       evt_ack;
  logic       clr_ovf;
  logic       tog_pulse;
  logic       evt_valid;
  logic [1:0] pending;
  logic [7:0] evt_count;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  toggle_pulse_decoder #(.CNT_W(8), .PEND_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt_ack   (evt_ack),
    .clr_ovf   (clr_ovf),
    .tog_pulse (tog_pulse),
    .evt_valid (evt_valid),
    .pending   (pending),
    .evt_count (evt_count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic a, input logic c);
    tog_in  = t;
    evt_ack = a;
    clr_ovf = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with tog_in held high: no event may appear after release.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("rst_pulse", tog_pulse, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_count", evt_count, 0);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_ovf", ovf, 0);
    waitCycles(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      checkOutput("hold_pulse", tog_pulse, 0);
      checkOutput("hold_count", evt_count, 0);
      checkOutput("hold_pending", pending, 0);
    end

    // Restart with tog_in low so that a genuine 0->1 transition can be issued.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("lat_pulse_e1", tog_pulse, 0);
    waitCycles(1);
    checkOutput("lat_pulse_e2", tog_pulse, 0);
    waitCycles(1);
    checkOutput("lat_pulse_e3", tog_pulse, 1);
    checkOutput("lat_count", evt_count, 1);
    checkOutput("lat_pending", pending, 1);
    checkOutput("lat_valid", evt_valid, 1);
    waitCycles(1);
    checkOutput("lat_pulse_end", tog_pulse, 0);

    // Five events with no ack: pending saturates at 3 and the fourth event overflows.
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(~tog_in, 1'b0, 1'b0);
      waitCycles(3);
      checkOutput("sat_pulse", tog_pulse, 1);
      checkOutput("sat_pending", pending, (i < 3) ? i + 1 : 3);
      checkOutput("sat_ovf", ovf, (i >= 3) ? 1 : 0);
      waitCycles(1);
    end
    checkOutput("sat_count", evt_count, 5);

    // One ack brings pending to 2, then an ack coincides with a detect.
    applyStimulus(tog_in, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(tog_in, 1'b0, 1'b0);
    checkOutput("ack_pending2", pending, 2);
    applyStimulus(~tog_in, 1'b0, 1'b0);
    waitCycles(2);
    applyStimulus(tog_in, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(tog_in, 1'b0, 1'b0);
    checkOutput("same_pulse", tog_pulse, 1);
    checkOutput("same_pending", pending, 2);
    checkOutput("same_count", evt_count, 6);
    checkOutput("same_ovf", ovf, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tog_in, 1'b1, 1'b0);
      waitCycles(1);
      applyStimulus(tog_in, 1'b0, 1'b0);
      checkOutput("ack_pending", pending, (i == 0) ? 1 : 0);
      checkOutput("ack_valid", evt_valid, (i == 0) ? 1 : 0);
    end

    // 256 events from a fresh reset wrap the 8-bit count back to zero.
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("wrap_start_count", evt_count, 0);
    checkOutput("wrap_start_ovf", ovf, 0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(~tog_in, 1'b0, 1'b0);
      waitCycles(2);
    end
    waitCycles(2);
    checkOutput("wrap_count255", evt_count, 255);
    checkOutput("wrap_pending", pending, 3);
    checkOutput("wrap_ovf", ovf, 1);
    applyStimulus(~tog_in, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("wrap_count0", evt_count, 0);
    applyStimulus(tog_in, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(tog_in, 1'b0, 1'b0);
    checkOutput("clr_ovf", ovf, 0);
    checkOutput("clr_pending", pending, 3);

    // clr_ovf in the same cycle as a new overflow leaves ovf set.
    applyStimulus(~tog_in, 1'b0, 1'b0);
    waitCycles(2);
    applyStimulus(tog_in, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(tog_in, 1'b0, 1'b0);
    checkOutput("clr_race_pulse", tog_pulse, 1);
    checkOutput("clr_race_ovf", ovf, 1);
    checkOutput("clr_race_count", evt_count, 1);

    // Asynchronous reset between edges with pending=2 and ovf=1.
    applyStimulus(tog_in, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(tog_in, 1'b0, 1'b0);
    checkOutput("pre_rst_pending", pending, 2);
    checkOutput("pre_rst_ovf", ovf, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_pulse", tog_pulse, 0);
    checkOutput("async_valid", evt_valid, 0);
    checkOutput("async_pending", pending, 0);
    checkOutput("async_count", evt_count, 0);
    checkOutput("async_ovf", ovf, 0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(5);
    checkOutput("post_rst_count", evt_count, 0);
    checkOutput("post_rst_pulse", tog_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
